// File: rtl/scr1_pipe_lsu_burst.sv
// Burst load/store unit: splits a multi-word EXU access into sequential word beats on DMEM.
// Define SCR1_LSU_BURST_OVERLAP_EN to issue the next beat in the cycle its predecessor responds.
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

module scr1_pipe_lsu_burst #(
    parameter int WORD_W    = 32,
    parameter int MAX_WORDS = 5,
    parameter int CNT_W     = $clog2(MAX_WORDS+1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          exu2lsu_req,
    input  logic                          exu2lsu_store,
    input  logic [CNT_W-1:0]              exu2lsu_nwords,
    input  logic [`SCR1_XLEN-1:0]         exu2lsu_addr,
    input  logic [MAX_WORDS*WORD_W-1:0]   exu2lsu_s_data,
    output logic                          lsu2exu_rdy,
    output logic [MAX_WORDS*WORD_W-1:0]   lsu2exu_l_data,
    output logic                          lsu2exu_exc,
    output logic [3:0]                    lsu2exu_exc_code,
    output logic                          lsu_busy,
    output logic                          lsu2dmem_req,
    output logic                          lsu2dmem_cmd,
    output logic [1:0]                    lsu2dmem_width,
    output logic [`SCR1_DMEM_AWIDTH-1:0]  lsu2dmem_addr,
    output logic [WORD_W-1:0]             lsu2dmem_wdata,
    input  logic                          dmem2lsu_req_ack,
    input  logic [WORD_W-1:0]             dmem2lsu_rdata,
    input  logic [1:0]                    dmem2lsu_resp
);

    localparam logic [3:0] SCR1_EXC_CODE_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] SCR1_EXC_CODE_LD_ADDR_MISALIGN = 4'd4;
    localparam logic [3:0] SCR1_EXC_CODE_LD_ACCESS_FAULT  = 4'd5;
    localparam logic [3:0] SCR1_EXC_CODE_ST_ADDR_MISALIGN = 4'd6;
    localparam logic [3:0] SCR1_EXC_CODE_ST_ACCESS_FAULT  = 4'd7;
    localparam logic       SCR1_MEM_CMD_RD          = 1'b0;
    localparam logic       SCR1_MEM_CMD_WR          = 1'b1;
    localparam logic [1:0] SCR1_MEM_WIDTH_WORD      = 2'b10;
    localparam logic [1:0] SCR1_MEM_RESP_RDY_OK     = 2'b01;
    localparam logic [1:0] SCR1_MEM_RESP_RDY_ER     = 2'b10;

`ifdef SCR1_LSU_BURST_OVERLAP_EN
    localparam bit OVERLAP_EN = 1'b1;
`else
    localparam bit OVERLAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e                        state;
    logic                          store_r;
    logic [CNT_W-1:0]              nwords_r;
    logic [CNT_W-1:0]              beat_r;
    logic [`SCR1_XLEN-1:0]         addr_r;
    logic [MAX_WORDS*WORD_W-1:0]   sdata_r;
    logic [MAX_WORDS*WORD_W-1:0]   ldata_r;
    logic                          fault_r;

    logic                          req_bad;
    logic                          idle_fault;
    logic                          last_beat;
    logic                          resp_ok;
    logic                          resp_er;
    logic                          overlap_req;
    logic [MAX_WORDS*WORD_W-1:0]   sdata_next;

    assign req_bad     = (exu2lsu_addr[1:0] != 2'b00) || (exu2lsu_nwords == '0)
                      || (exu2lsu_nwords > CNT_W'(MAX_WORDS));
    assign idle_fault  = (state == ST_IDLE) && exu2lsu_req && req_bad;
    assign last_beat   = (beat_r == nwords_r - CNT_W'(1));
    assign resp_ok     = (dmem2lsu_resp == SCR1_MEM_RESP_RDY_OK);
    assign resp_er     = (dmem2lsu_resp == SCR1_MEM_RESP_RDY_ER);
    // Store words are consumed from the bottom, so the current beat is always word 0.
    assign sdata_next  = sdata_r >> WORD_W;
    assign overlap_req = OVERLAP_EN && (state == ST_WAIT) && resp_ok && !last_beat;

    assign lsu2dmem_req   = (state == ST_ISSUE) || overlap_req;
    assign lsu2dmem_cmd   = store_r ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    assign lsu2dmem_width = SCR1_MEM_WIDTH_WORD;
    assign lsu2dmem_addr  = `SCR1_DMEM_AWIDTH'(overlap_req ? addr_r + `SCR1_XLEN'(4) : addr_r);
    assign lsu2dmem_wdata = overlap_req ? sdata_next[WORD_W-1:0] : sdata_r[WORD_W-1:0];

    assign lsu_busy       = (state != ST_IDLE);
    assign lsu2exu_rdy    = (state == ST_DONE) || idle_fault;
    assign lsu2exu_exc    = ((state == ST_DONE) && fault_r) || idle_fault;
    assign lsu2exu_l_data = ldata_r;

    always_comb begin
        lsu2exu_exc_code = SCR1_EXC_CODE_INSTR_MISALIGN;
        if (idle_fault) begin
            lsu2exu_exc_code = exu2lsu_store ? SCR1_EXC_CODE_ST_ADDR_MISALIGN
                                             : SCR1_EXC_CODE_LD_ADDR_MISALIGN;
        end else if ((state == ST_DONE) && fault_r) begin
            lsu2exu_exc_code = store_r ? SCR1_EXC_CODE_ST_ACCESS_FAULT
                                       : SCR1_EXC_CODE_LD_ACCESS_FAULT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            store_r  <= 1'b0;
            nwords_r <= '0;
            beat_r   <= '0;
            addr_r   <= '0;
            sdata_r  <= '0;
            ldata_r  <= '0;
            fault_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (exu2lsu_req && !req_bad) begin
                        store_r  <= exu2lsu_store;
                        nwords_r <= exu2lsu_nwords;
                        addr_r   <= exu2lsu_addr;
                        sdata_r  <= exu2lsu_s_data;
                        beat_r   <= '0;
                        ldata_r  <= '0;
                        fault_r  <= 1'b0;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (dmem2lsu_req_ack) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (resp_ok) begin
                        if (!store_r) begin
                            for (int k = 0; k < MAX_WORDS; k++) begin
                                if (beat_r == CNT_W'(k)) begin
                                    ldata_r[k*WORD_W +: WORD_W] <= dmem2lsu_rdata;
                                end
                            end
                        end
                        if (last_beat) begin
                            state <= ST_DONE;
                        end else begin
                            beat_r  <= beat_r + CNT_W'(1);
                            addr_r  <= addr_r + `SCR1_XLEN'(4);
                            sdata_r <= sdata_next;
                            // An acked overlapped request already has its response pending.
                            state   <= (overlap_req && dmem2lsu_req_ack) ? ST_WAIT : ST_ISSUE;
                        end
                    end else if (resp_er) begin
                        fault_r <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_pipe_lsu_burst.sv
// Directed bench for scr1_pipe_lsu_burst: word-beat slave model plus a burst-level reference model.
`timescale 1ns/1ps
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

module tb_scr1_pipe_lsu_burst;

    localparam int WORD_W    = 32;
    localparam int MAX_WORDS = 5;
    localparam int CNT_W     = 3;
    localparam int DW        = MAX_WORDS*WORD_W;

    localparam logic [3:0] EXC_NONE = 4'd0;
    localparam logic [3:0] LD_MIS   = 4'd4;
    localparam logic [3:0] LD_ACC   = 4'd5;
    localparam logic [3:0] ST_MIS   = 4'd6;
    localparam logic [3:0] ST_ACC   = 4'd7;
    localparam logic [1:0] R_NOTRDY = 2'b00;
    localparam logic [1:0] R_OK     = 2'b01;
    localparam logic [1:0] R_ER     = 2'b10;

`ifdef SCR1_LSU_BURST_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          exu2lsu_req;
    logic                          exu2lsu_store;
    logic [CNT_W-1:0]              exu2lsu_nwords;
    logic [`SCR1_XLEN-1:0]         exu2lsu_addr;
    logic [DW-1:0]                 exu2lsu_s_data;
    logic                          lsu2exu_rdy;
    logic [DW-1:0]                 lsu2exu_l_data;
    logic                          lsu2exu_exc;
    logic [3:0]                    lsu2exu_exc_code;
    logic                          lsu_busy;
    logic                          lsu2dmem_req;
    logic                          lsu2dmem_cmd;
    logic [1:0]                    lsu2dmem_width;
    logic [`SCR1_DMEM_AWIDTH-1:0]  lsu2dmem_addr;
    logic [WORD_W-1:0]             lsu2dmem_wdata;
    logic                          dmem2lsu_req_ack;
    logic [WORD_W-1:0]             dmem2lsu_rdata;
    logic [1:0]                    dmem2lsu_resp;

    always #5 clk = ~clk;

    scr1_pipe_lsu_burst #(.WORD_W(WORD_W), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .exu2lsu_req      (exu2lsu_req),
        .exu2lsu_store    (exu2lsu_store),
        .exu2lsu_nwords   (exu2lsu_nwords),
        .exu2lsu_addr     (exu2lsu_addr),
        .exu2lsu_s_data   (exu2lsu_s_data),
        .lsu2exu_rdy      (lsu2exu_rdy),
        .lsu2exu_l_data   (lsu2exu_l_data),
        .lsu2exu_exc      (lsu2exu_exc),
        .lsu2exu_exc_code (lsu2exu_exc_code),
        .lsu_busy         (lsu_busy),
        .lsu2dmem_req     (lsu2dmem_req),
        .lsu2dmem_cmd     (lsu2dmem_cmd),
        .lsu2dmem_width   (lsu2dmem_width),
        .lsu2dmem_addr    (lsu2dmem_addr),
        .lsu2dmem_wdata   (lsu2dmem_wdata),
        .dmem2lsu_req_ack (dmem2lsu_req_ack),
        .dmem2lsu_rdata   (dmem2lsu_rdata),
        .dmem2lsu_resp    (dmem2lsu_resp)
    );

    // Slave acks every request in its own cycle.
    assign dmem2lsu_req_ack = lsu2dmem_req;

    int             errors = 0;
    int             checks = 0;
    logic [31:0]    mem [bit [31:0]];
    int             slv_beat;
    int             err_beat_g;
    logic [DW-1:0]  exp_ldata;
    logic [31:0]    obs_addr [$];
    int             last_lat;
    logic [3:0]     last_code;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response arrives the cycle after an acked request; beat err_beat_g answers RDY_ER.
    initial begin : slave
        logic        pend;
        logic [31:0] paddr;
        dmem2lsu_resp  = R_NOTRDY;
        dmem2lsu_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            pend  = lsu2dmem_req && dmem2lsu_req_ack && rst_n;
            paddr = lsu2dmem_addr;
            @(posedge clk);
            #1;
            if (pend) begin
                dmem2lsu_resp  = (slv_beat == err_beat_g) ? R_ER : R_OK;
                dmem2lsu_rdata = mem_rd(paddr);
                slv_beat++;
            end else begin
                dmem2lsu_resp  = R_NOTRDY;
                dmem2lsu_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic idle_check(input string name);
        @(negedge clk);
        chk({name, " idle busy"}, DW'(lsu_busy), '0);
        chk({name, " idle req"}, DW'(lsu2dmem_req), '0);
        chk({name, " idle rdy"}, DW'(lsu2exu_rdy), '0);
        chk({name, " idle l_data"}, lsu2exu_l_data, exp_ldata);
        @(posedge clk);
        #1;
    endtask

    // Starts at posedge+1 (cycle 0 = request cycle) and returns at posedge+1.
    task automatic run_burst(input string name, input bit st, input int nw, input logic [31:0] a,
                             input logic [DW-1:0] sd, input int err_b);
        bit          bad;
        bit          fault;
        bit          seen;
        int          nbeats;
        int          lat;
        int          cyc;
        logic [31:0] e_addr [$];
        logic [31:0] e_wdata [$];
        logic [31:0] ea;
        logic [31:0] ew;
        logic [3:0]  e_code;

        bad    = (a[1:0] != 2'b00) || (nw < 1) || (nw > MAX_WORDS);
        fault  = !bad && (err_b >= 0) && (err_b < nw);
        nbeats = bad ? 0 : (fault ? err_b + 1 : nw);
        lat    = bad ? 0 : (OVL ? nbeats + 2 : 2*nbeats + 1);
        for (int k = 0; k < nbeats; k++) begin
            e_addr.push_back(a + 32'(4*k));
            e_wdata.push_back(sd[k*WORD_W +: WORD_W]);
        end
        if (!bad) begin
            exp_ldata = '0;
            if (!st) begin
                for (int k = 0; k < (fault ? err_b : nw); k++) begin
                    exp_ldata[k*WORD_W +: WORD_W] = mem_rd(a + 32'(4*k));
                end
            end
        end
        e_code = bad ? (st ? ST_MIS : LD_MIS) : (fault ? (st ? ST_ACC : LD_ACC) : EXC_NONE);

        obs_addr.delete();
        err_beat_g     = err_b;
        slv_beat       = 0;
        last_lat       = lat;
        last_code      = 4'hF;
        exu2lsu_req    = 1'b1;
        exu2lsu_store  = st;
        exu2lsu_nwords = CNT_W'(nw);
        exu2lsu_addr   = a;
        exu2lsu_s_data = sd;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc <= lat + 20) begin
            @(negedge clk);
            if (lsu2dmem_req) begin
                obs_addr.push_back(lsu2dmem_addr);
                if (e_addr.size() == 0) begin
                    chk({name, " unexpected beat"}, DW'(lsu2dmem_addr), '1);
                end else begin
                    ea = e_addr.pop_front();
                    ew = e_wdata.pop_front();
                    chk({name, " beat addr"}, DW'(lsu2dmem_addr), DW'(ea));
                    chk({name, " beat cmd"}, DW'(lsu2dmem_cmd), DW'(st));
                    chk({name, " beat width"}, DW'(lsu2dmem_width), DW'(2'b10));
                    if (st) chk({name, " beat wdata"}, DW'(lsu2dmem_wdata), DW'(ew));
                end
            end
            chk({name, " busy"}, DW'(lsu_busy), DW'(!bad && cyc >= 1));
            chk({name, " rdy"}, DW'(lsu2exu_rdy), DW'(cyc == lat));
            if (lsu2exu_rdy) begin
                seen      = 1'b1;
                last_code = lsu2exu_exc_code;
                chk({name, " exc"}, DW'(lsu2exu_exc), DW'(e_code != EXC_NONE));
                chk({name, " exc_code"}, DW'(lsu2exu_exc_code), DW'(e_code));
                chk({name, " l_data"}, lsu2exu_l_data, exp_ldata);
            end
            @(posedge clk);
            #1;
            if (cyc == 0 && !bad) begin
                exu2lsu_store  = ~st;
                exu2lsu_nwords = '0;
                exu2lsu_addr   = 32'h0000_0003;
                exu2lsu_s_data = ~sd;
            end
            if (seen) exu2lsu_req = 1'b0;
            cyc++;
        end
        exu2lsu_req = 1'b0;
        if (!seen) chk({name, " rdy timeout"}, DW'(cyc), DW'(lat));
        chk({name, " beats left"}, DW'(e_addr.size()), '0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [DW-1:0] sd5;
        rst_n          = 1'b0;
        exu2lsu_req    = 1'b0;
        exu2lsu_store  = 1'b0;
        exu2lsu_nwords = '0;
        exu2lsu_addr   = '0;
        exu2lsu_s_data = '0;
        err_beat_g     = -1;
        slv_beat       = 0;
        exp_ldata      = '0;
        mem[32'h100] = 32'h11;
        mem[32'h104] = 32'h22;
        mem[32'h108] = 32'h33;
        sd5 = {32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", DW'(lsu_busy), '0);
        chk("reset req", DW'(lsu2dmem_req), '0);
        chk("reset rdy", DW'(lsu2exu_rdy), '0);
        chk("reset cmd", DW'(lsu2dmem_cmd), '0);
        chk("reset code", DW'(lsu2exu_exc_code), '0);
        chk("reset l_data", lsu2exu_l_data, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_check("post reset");

        run_burst("ld3", 1'b0, 3, 32'h100, '0, -1);
        chk("ld3 latency literal", DW'(last_lat), DW'(OVL ? 5 : 7));
        chk("ld3 l_data literal", lsu2exu_l_data, {64'h0, 32'h33, 32'h22, 32'h11});
        chk("ld3 beat count", DW'(obs_addr.size()), DW'(3));
        idle_check("ld3");

        run_burst("st5", 1'b1, 5, 32'h200, sd5, -1);
        chk("st5 last addr literal", DW'(obs_addr[obs_addr.size()-1]), DW'(32'h210));
        chk("st5 beat count", DW'(obs_addr.size()), DW'(5));
        idle_check("st5");

        run_burst("ld misalign", 1'b0, 3, 32'h102, '0, -1);
        chk("ld misalign code literal", DW'(last_code), DW'(4'd4));
        chk("ld misalign no beats", DW'(obs_addr.size()), '0);
        run_burst("ld n0", 1'b0, 0, 32'h100, '0, -1);
        run_burst("ld n6", 1'b0, 6, 32'h100, '0, -1);
        chk("ld n6 no beats", DW'(obs_addr.size()), '0);
        run_burst("st misalign", 1'b1, 2, 32'h201, sd5, -1);
        idle_check("misalign");

        run_burst("st4 fault", 1'b1, 4, 32'h300, sd5, 1);
        chk("st4 fault code literal", DW'(last_code), DW'(4'd7));
        chk("st4 fault beat count", DW'(obs_addr.size()), DW'(2));
        idle_check("st4 fault");

        run_burst("ld5 fault", 1'b0, 5, 32'h400, '0, 3);
        idle_check("ld5 fault");

        run_burst("ld wrap", 1'b0, 2, 32'hFFFF_FFFC, '0, -1);
        chk("ld wrap addr0 literal", DW'(obs_addr[0]), DW'(32'hFFFF_FFFC));
        chk("ld wrap addr1 literal", DW'(obs_addr[1]), DW'(32'h0));
        idle_check("ld wrap");

        run_burst("ld1", 1'b0, 1, 32'h104, '0, -1);
        chk("ld1 l_data literal", lsu2exu_l_data, {128'h0, 32'h22});

        // Reset while a beat response is outstanding.
        err_beat_g     = -1;
        slv_beat       = 0;
        exu2lsu_req    = 1'b1;
        exu2lsu_store  = 1'b0;
        exu2lsu_nwords = CNT_W'(3);
        exu2lsu_addr   = 32'h500;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid-burst busy", DW'(lsu_busy), DW'(1));
        rst_n       = 1'b0;
        exu2lsu_req = 1'b0;
        #1;
        chk("rst busy", DW'(lsu_busy), '0);
        chk("rst req", DW'(lsu2dmem_req), '0);
        chk("rst l_data", lsu2exu_l_data, '0);
        exp_ldata = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_check("after rst");
        run_burst("ld3 after rst", 1'b0, 3, 32'h100, '0, -1);
        idle_check("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
